// File: rtl/frec_pkg.sv
// Shared types and constants for the frequency-change sequencer.
// FSM state encoding plus default and maximum legal frequency numbers.
package frec_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_LOW,
    ST_APPLY,
    ST_DONE,
    ST_DONE_N
  } state_e;

  localparam int FREC_DEF_NUM = 1;
  localparam int FREC_MAX_NUM = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at/after ptr.
// Ports: req, ptr in; one-hot gnt and valid out.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/frec_change_ctrl.sv
// Arbitrating sequencer owning the divider frequency-select input.
// Ports: clk, reset(n), req/req_num, clkdiv_in in; ack, nak, busy, frec_sel, div_rst, tmo_flag out.
module frec_change_ctrl
  import frec_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int NUMW    = 8,
  parameter int DEF_NUM = FREC_DEF_NUM,
  parameter int MAX_NUM = FREC_MAX_NUM,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*NUMW-1:0] req_num,
  input  logic               clkdiv_in,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    nak,
  output logic               busy,
  output logic [NUMW-1:0]    frec_sel,
  output logic               div_rst,
  output logic               tmo_flag
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = 4;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [NUMW-1:0]   gnum_q, gnum_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [NUMW-1:0]   sel_q, sel_d;
  logic              drst_q, drst_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   nak_q, nak_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;

  logic [NREQ-1:0]   gnt;
  logic              gnt_vld;
  logic [PW-1:0]     a_idx;
  logic [NUMW-1:0]   num_arr [NREQ];

  logic num_ok, num_same, tmo_hit, wait_exit, apply_end;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .valid (gnt_vld)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_num
    assign num_arr[g] = req_num[g*NUMW +: NUMW];
  end

  always_comb begin
    a_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) a_idx = PW'(i);
    end
  end

  assign num_ok    = (gnum_q != '0) &&
                     (gnum_q <= NUMW'(MAX_NUM));
  assign num_same  = (gnum_q == sel_q);
  assign tmo_hit   = (wcnt_q == TW'(TIMEOUT - 1));
  // Low sample means the next divided edge is far enough away.
  assign wait_exit = !clkdiv_in || tmo_hit;
  assign apply_end = (rcnt_q == RW'(RST_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnum_q  <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      sel_q   <= NUMW'(DEF_NUM);
      drst_q  <= 1'b1;
      ack_q   <= '0;
      nak_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnum_q  <= gnum_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      sel_q   <= sel_d;
      drst_q  <= drst_d;
      ack_q   <= ack_d;
      nak_q   <= nak_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:     state_d = ST_IDLE;
      ST_IDLE:     if (gnt_vld) state_d = ST_CHECK;
      ST_CHECK: begin
        if (!num_ok || num_same) state_d = ST_DONE_N;
        else                     state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: if (wait_exit) state_d = ST_APPLY;
      ST_APPLY:    if (apply_end) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      ST_DONE_N:   state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    gidx_d = gidx_q;
    gnum_d = gnum_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    sel_d  = sel_q;
    drst_d = drst_q;
    ack_d  = '0;
    nak_d  = '0;
    busy_d = busy_q;
    tmo_d  = tmo_q;
    unique case (state_q)
      ST_INIT: drst_d = 1'b0;
      ST_IDLE: begin
        if (gnt_vld) begin
          gidx_d = a_idx;
          gnum_d = num_arr[a_idx];
          busy_d = 1'b1;
          if (a_idx == PW'(NREQ - 1)) ptr_d = '0;
          else                        ptr_d = a_idx + PW'(1);
        end
      end
      ST_CHECK: begin
        if (!num_ok)       nak_d = NREQ'(1) << gidx_q;
        else if (num_same) ack_d = NREQ'(1) << gidx_q;
        else               wcnt_d = '0;
      end
      ST_WAIT_LOW: begin
        if (wait_exit) begin
          sel_d  = gnum_q;
          drst_d = 1'b1;
          rcnt_d = '0;
          if (clkdiv_in) tmo_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      ST_APPLY: begin
        if (apply_end) begin
          drst_d = 1'b0;
          ack_d  = NREQ'(1) << gidx_q;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      ST_DONE:   busy_d = 1'b0;
      ST_DONE_N: busy_d = 1'b0;
      default: ;
    endcase
  end

  assign ack      = ack_q;
  assign nak      = nak_q;
  assign busy     = busy_q;
  assign frec_sel = sel_q;
  assign div_rst  = drst_q;
  assign tmo_flag = tmo_q;

endmodule

// File: tb/tb_frec_change_ctrl.sv
// Self-checking bench for frec_change_ctrl.
// Directed scenarios followed by randomized traffic against a transaction-level model.
module tb_frec_change_ctrl;

  localparam int NREQ    = 2;
  localparam int NUMW    = 8;
  localparam int RST_CYC = 2;
  localparam int TIMEOUT = 4096;
  localparam int MAXN    = 15;
  localparam int DEFN    = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*NUMW-1:0] req_num = '0;
  logic clkdiv_in = 1'b0;
  logic [NREQ-1:0] ack, nak;
  logic busy, div_rst, tmo_flag;
  logic [NUMW-1:0] frec_sel;

  always #5 clk = ~clk;

  frec_change_ctrl #(
    .NREQ    (NREQ),
    .NUMW    (NUMW),
    .DEF_NUM (DEFN),
    .MAX_NUM (MAXN),
    .RST_CYC (RST_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_num   (req_num),
    .clkdiv_in (clkdiv_in),
    .ack       (ack),
    .nak       (nak),
    .busy      (busy),
    .frec_sel  (frec_sel),
    .div_rst   (div_rst),
    .tmo_flag  (tmo_flag)
  );

  int errs = 0;
  int checks = 0;

  int m_sel = DEFN;
  int m_ptr = 0;
  bit m_tmo = 1'b0;
  logic [NREQ-1:0] pend = '0;
  int nums [NREQ];

  int clk_mode = 0;
  bit rise_chk = 1'b1;
  logic clk_drv = 1'b0;
  logic rst_prev = 1'b1;
  logic [NUMW-1:0] sel_prev = NUMW'(DEFN);
  int rst_cnt = 0;
  int lat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, then drive clkdiv for the next rise.
  task automatic step();
    @(negedge clk);
    if (rise_chk && div_rst && !rst_prev)
      chk("rise_while_low", clk_drv, 0);
    if (frec_sel !== sel_prev)
      chk("sel_chg_in_rst", div_rst, 1);
    if (div_rst) rst_cnt++;
    rst_prev = div_rst;
    sel_prev = frec_sel;
    case (clk_mode)
      0: clkdiv_in = 1'b0;
      1: clkdiv_in = 1'b1;
      default: clkdiv_in = 1'($urandom_range(0, 1));
    endcase
    clk_drv = clkdiv_in;
  endtask

  task automatic raise(input int i, input int num);
    nums[i] = num;
    req_num[i*NUMW +: NUMW] = NUMW'(num);
    req[i] = 1'b1;
    pend[i] = 1'b1;
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < NREQ; k++)
      if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic int pick_num();
    if ($urandom_range(0, 9) < 3) return m_sel;
    return int'($urandom_range(0, 17));
  endfunction

  // Serve every pending request, predicting winner, outcome and side effects.
  task automatic serve(input int max_add, output int last_lat);
    int w, num, add, n, j;
    bit legal, apply;
    logic [NREQ-1:0] ea, en;
    add = 0;
    last_lat = 0;
    while (pend != '0) begin
      n = 0;
      rst_cnt = 0;
      do begin
        step();
        n++;
      end while ((ack | nak) == '0 && n < 5000);
      if (n >= 5000) begin
        chk("event_timeout", 0, 1);
        req = '0;
        pend = '0;
        break;
      end
      w = rr_pick();
      num = nums[w];
      legal = (num != 0) && (num <= MAXN);
      apply = legal && (num != m_sel);
      ea = '0;
      en = '0;
      if (legal) ea[w] = 1'b1;
      else       en[w] = 1'b1;
      if (apply) m_sel = num;
      m_ptr = (w + 1) % NREQ;
      chk("ack_nak", {ack, nak}, {ea, en});
      chk("frec_sel", frec_sel, m_sel);
      chk("div_rst_cycles", rst_cnt, apply ? RST_CYC : 0);
      chk("busy_evt", busy, 1);
      chk("tmo_flag", tmo_flag, m_tmo);
      last_lat = n;
      pend[w] = 1'b0;
      req[w] = 1'b0;
      if (add < max_add && $urandom_range(0, 1) == 1) begin
        j = int'($urandom_range(0, NREQ - 1));
        if (!pend[j] && j != w) begin
          raise(j, pick_num());
          add++;
        end
      end
    end
    step();
    chk("busy_idle", busy, 0);
    chk("quiet_idle", {ack, nak}, 0);
  endtask

  initial begin
    int n;
    // Reset state
    reset = 1'b0;
    repeat (3) step();
    chk("rst_sel", frec_sel, DEFN);
    chk("rst_div_rst", div_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack_nak", {ack, nak}, 0);
    chk("rst_tmo", tmo_flag, 0);
    reset = 1'b1;
    step();
    chk("init_div_rst", div_rst, 0);
    chk("init_busy", busy, 0);
    repeat (3) step();
    chk("idle_quiet", {ack, nak, div_rst}, 0);

    // Simultaneous requests, round-robin from pointer 0
    raise(0, 4);
    raise(1, 7);
    serve(0, lat);

    // Single legal change with clkdiv low
    raise(0, 5);
    serve(0, lat);
    chk("lat_apply", lat, 5);

    // Illegal numbers and no-op request
    raise(1, 0);
    serve(0, lat);
    chk("lat_nak0", lat, 2);
    raise(1, 16);
    serve(0, lat);
    chk("lat_nak16", lat, 2);
    raise(0, m_sel);
    serve(0, lat);
    chk("lat_noop", lat, 2);

    // Forced change by timeout, flag sticky afterwards
    clk_mode = 1;
    clkdiv_in = 1'b1;
    clk_drv = 1'b1;
    rise_chk = 1'b0;
    m_tmo = 1'b1;
    raise(0, 9);
    serve(0, lat);
    chk("lat_timeout", lat, 1 + TIMEOUT + RST_CYC + 1);
    clk_mode = 0;
    clkdiv_in = 1'b0;
    clk_drv = 1'b0;
    rise_chk = 1'b1;
    raise(1, 3);
    serve(0, lat);
    chk("tmo_sticky", tmo_flag, 1);

    // Reset in the middle of APPLY
    raise(1, 9);
    n = 0;
    do begin
      step();
      n++;
    end while (!div_rst && n < 20);
    chk("reached_apply", div_rst, 1);
    reset = 1'b0;
    req = '0;
    pend = '0;
    m_sel = DEFN;
    m_ptr = 0;
    m_tmo = 1'b0;
    step();
    chk("mid_rst_sel", frec_sel, DEFN);
    chk("mid_rst_div", div_rst, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", {ack, nak}, 0);
    chk("mid_rst_tmo", tmo_flag, 0);
    reset = 1'b1;
    step();
    chk("rel_div_rst", div_rst, 0);
    raise(0, 6);
    serve(0, lat);
    chk("lat_after_rst", lat, 5);

    // Randomized traffic with a random clkdiv
    clk_mode = 2;
    for (int t = 0; t < 150; t++) begin
      int mask;
      mask = int'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        if (mask[i]) raise(i, pick_num());
      serve(2, lat);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
